mem_bus_arbiter: RTL and testbench

Two-master arbiter sharing the single core data/instruction memory port between instruction fetch (IF) and the load/store path (LS), which feeds the MEM stage. It grants one transaction at a time with load/store priority and a starvation bound for fetch. It tracks the single outstanding transaction and routes the response back to its owner. It drops fetch responses invalidated by a pipeline flush.

---
 rtl/mem_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one memory port between instruction fetch (IF) and load/store (LS), one outstanding txn.
// Latency: request to bus_req_o 0 cycles; bus_rvalid_i to if/ls_rvalid_o 0 cycles; 1 txn/cycle sustained.
// Backpressure: requests wait (ungranted) while a txn is outstanding or bus_gnt_i is low; no response backpressure.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   if_req_i/if_addr_i         fetch request (held until if_gnt_o), fetch address
//   if_flush_i                 kill pending/arriving fetch response, blocks IF grant this cycle
//   if_gnt_o/if_rvalid_o/if_rdata_o   fetch grant, response valid, response data
//   ls_req_i/ls_we_i/ls_addr_i/ls_wstrb_i/ls_wdata_i   load/store request fields
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o   LS grant, load data valid / store ack, raw load word
//   bus_req_o/bus_we_o/bus_addr_o/bus_wdata_o/bus_be_o   memory request side
//   bus_gnt_i/bus_rvalid_i/bus_rdata_i   memory accept, response valid, response data
//   arb_busy_o                 a transaction is outstanding

`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               if_req_i,
  input  logic [`XLEN-1:0]   if_addr_i,
  input  logic               if_flush_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [`XLEN-1:0]   if_rdata_o,

  input  logic               ls_req_i,
  input  logic               ls_we_i,
  input  logic [`XLEN-1:0]   ls_addr_i,
  input  logic [3:0]         ls_wstrb_i,
  input  logic [`XLEN-1:0]   ls_wdata_i,
  output logic               ls_gnt_o,
  output logic               ls_rvalid_o,
  output logic [`XLEN-1:0]   ls_rdata_o,

  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [`XLEN-1:0]   bus_addr_o,
  output logic [`XLEN-1:0]   bus_wdata_o,
  output logic [3:0]         bus_be_o,
  input  logic               bus_gnt_i,
  input  logic               bus_rvalid_i,
  input  logic [`XLEN-1:0]   bus_rdata_i,

  output logic               arb_busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_PEND = 2'd1,
    LS_PEND = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       drop_q, drop_d;

  logic       pending;
  logic       can_issue;
  logic       if_req_eff;
  logic       sel_ls;
  logic       sel_if;
  logic       req_any;
  logic       accept;
  logic       if_gnt_raw;
  logic       ls_gnt_raw;
  logic       if_rvalid_raw;
  logic       ls_rvalid_raw;

  // ---------------------------------------------------------------------
  // Issue selection
  // ---------------------------------------------------------------------
  assign pending    = (state_q != IDLE);
  // A new request may go out in the same cycle the outstanding response
  // returns, which is what gives back-to-back throughput.
  assign can_issue  = !pending || bus_rvalid_i;
  // A flushed fetch must not be issued: its address is already stale.
  assign if_req_eff = if_req_i && !if_flush_i;

  // LS has priority unless IF has been passed over STARVE_LIMIT times in a row.
  assign sel_ls  = can_issue && ls_req_i && (!if_req_eff || (starve_cnt_q < LIMIT));
  assign sel_if  = can_issue && !sel_ls && if_req_eff;
  assign req_any = sel_ls || sel_if;
  assign accept  = req_any && bus_gnt_i;

  assign ls_gnt_raw = sel_ls && bus_gnt_i;
  assign if_gnt_raw = sel_if && bus_gnt_i;

  // ---------------------------------------------------------------------
  // Request field mux
  // ---------------------------------------------------------------------
  always_comb begin
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_be_o    = 4'b0000;
    if (sel_ls) begin
      bus_we_o    = ls_we_i;
      bus_addr_o  = ls_addr_i;
      bus_wdata_o = ls_wdata_i;
      // Loads always fetch the whole word; MEM stage extracts the bytes.
      bus_be_o    = ls_we_i ? ls_wstrb_i : 4'b1111;
    end else if (sel_if) begin
      bus_addr_o  = if_addr_i;
      bus_be_o    = 4'b1111;
    end
  end

  // ---------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------
  // A stray bus_rvalid_i in IDLE matches neither term and is ignored.
  assign ls_rvalid_raw = (state_q == LS_PEND) && bus_rvalid_i;
  // A flush in the response cycle kills the response directly; an earlier
  // flush is remembered in drop_q.
  assign if_rvalid_raw = (state_q == IF_PEND) && bus_rvalid_i && !drop_q && !if_flush_i;

  assign if_rdata_o = bus_rdata_i;
  assign ls_rdata_o = bus_rdata_i;

  // Handshake outputs are forced low while reset is held so that neither
  // master nor slave sees a transfer during reset.
  assign bus_req_o   = rst_n && req_any;
  assign if_gnt_o    = rst_n && if_gnt_raw;
  assign ls_gnt_o    = rst_n && ls_gnt_raw;
  assign if_rvalid_o = rst_n && if_rvalid_raw;
  assign ls_rvalid_o = rst_n && ls_rvalid_raw;
  assign arb_busy_o  = rst_n && pending;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = sel_ls ? LS_PEND : IF_PEND;
    end else if (pending && bus_rvalid_i) begin
      state_d = IDLE;
    end
  end

  // drop_q marks the outstanding fetch as flushed; it only lives for the
  // duration of one IF_PEND transaction.
  always_comb begin
    drop_d = drop_q;
    if (state_q == IF_PEND) begin
      if (bus_rvalid_i) begin
        drop_d = 1'b0;
      end else if (if_flush_i) begin
        drop_d = 1'b1;
      end
    end else begin
      drop_d = 1'b0;
    end
  end

  // Counts LS grants that happened while IF was waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt_raw || !if_req_i) begin
      starve_cnt_d = 4'd0;
    end else if (ls_gnt_raw && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arbiter;

  logic              clk;
  logic              rst_n;
  logic              if_req_i;
  logic [`XLEN-1:0]  if_addr_i;
  logic              if_flush_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [`XLEN-1:0]  if_rdata_o;
  logic              ls_req_i;
  logic              ls_we_i;
  logic [`XLEN-1:0]  ls_addr_i;
  logic [3:0]        ls_wstrb_i;
  logic [`XLEN-1:0]  ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [`XLEN-1:0]  ls_rdata_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [`XLEN-1:0]  bus_addr_o;
  logic [`XLEN-1:0]  bus_wdata_o;
  logic [3:0]        bus_be_o;
  logic              bus_gnt_i;
  logic              bus_rvalid_i;
  logic [`XLEN-1:0]  bus_rdata_i;
  logic              arb_busy_o;

  int n_chk;
  int n_fail;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wstrb_i(ls_wstrb_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .arb_busy_o(arb_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ifr;
    logic [31:0] ifa;
    logic        fl;
    logic        lsr;
    logic        we;
    logic [31:0] lsa;
    logic [3:0]  st;
    logic [31:0] wd;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_ifg;
    logic        e_lsg;
    logic        e_ifv;
    logic        e_lsv;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name,
      logic ifr, logic [31:0] ifa, logic fl,
      logic lsr, logic we, logic [31:0] lsa, logic [3:0] st, logic [31:0] wd,
      logic g, logic rv, logic [31:0] rd,
      logic e_req, logic e_we, logic [31:0] e_addr, logic [3:0] e_be, logic [31:0] e_wd,
      logic e_ifg, logic e_lsg, logic e_ifv, logic e_lsv, logic e_busy);
    vec_t v;
    v.name = name; v.ifr = ifr; v.ifa = ifa; v.fl = fl;
    v.lsr = lsr; v.we = we; v.lsa = lsa; v.st = st; v.wd = wd;
    v.g = g; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd;
    v.e_ifg = e_ifg; v.e_lsg = e_lsg; v.e_ifv = e_ifv; v.e_lsv = e_lsv; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic ifr, logic [31:0] ifa, logic fl, logic lsr, logic we,
                       logic [31:0] lsa, logic [3:0] st, logic [31:0] wd,
                       logic g, logic rv, logic [31:0] rd);
    if_req_i = ifr; if_addr_i = ifa; if_flush_i = fl;
    ls_req_i = lsr; ls_we_i = we; ls_addr_i = lsa; ls_wstrb_i = st; ls_wdata_i = wd;
    bus_gnt_i = g; bus_rvalid_i = rv; bus_rdata_i = rd;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    // Request held during reset must not leak onto the bus.
    drive(1, 32'h40, 0, 1, 0, 32'h80, 4'h0, 32'h0, 1, 1, 32'h0);

    //                   name        ifr ifa        fl lsr we lsa        st    wd           g  rv rd            req we addr       be    wd          ifg lsg ifv lsv busy
    vq.push_back(mk("idle",       0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 0));
    vq.push_back(mk("ld_req",     0, 32'h0,   0, 1, 0, 32'h100, 4'h0, 32'h0,    1, 0, 32'h0,        1, 0, 32'h100, 4'hf, 32'h0,    0, 1, 0, 0, 0));
    vq.push_back(mk("ld_rsp",     0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'hDEADBEEF, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 1, 1));
    vq.push_back(mk("idle2",      0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 0));
    vq.push_back(mk("st_req",     0, 32'h0,   0, 1, 1, 32'h200, 4'h3, 32'h1234, 1, 0, 32'h0,        1, 1, 32'h200, 4'h3, 32'h1234, 0, 1, 0, 0, 0));
    vq.push_back(mk("st_ack",     0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 1, 1));
    vq.push_back(mk("ld_nogt",    0, 32'h0,   0, 1, 0, 32'h300, 4'h0, 32'h0,    0, 0, 32'h0,        1, 0, 32'h300, 4'hf, 32'h0,    0, 0, 0, 0, 0));
    vq.push_back(mk("ld_gt",      0, 32'h0,   0, 1, 0, 32'h300, 4'h0, 32'h0,    1, 0, 32'h0,        1, 0, 32'h300, 4'hf, 32'h0,    0, 1, 0, 0, 0));
    vq.push_back(mk("ld_wait",    0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    1, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 1));
    vq.push_back(mk("ld_rsp2",    0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'hCAFE0001, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 1, 1));
    vq.push_back(mk("if_req",     1, 32'h400, 0, 0, 0, 32'h0,   4'h0, 32'h0,    1, 0, 32'h0,        1, 0, 32'h400, 4'hf, 32'h0,    1, 0, 0, 0, 0));
    vq.push_back(mk("b2b",        0, 32'h0,   0, 1, 0, 32'h500, 4'h0, 32'h0,    1, 1, 32'h11112222, 1, 0, 32'h500, 4'hf, 32'h0,    0, 1, 1, 0, 1));
    vq.push_back(mk("b2b_rsp",    0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'h33334444, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 1, 1));
    vq.push_back(mk("if_req2",    1, 32'h600, 0, 0, 0, 32'h0,   4'h0, 32'h0,    1, 0, 32'h0,        1, 0, 32'h600, 4'hf, 32'h0,    1, 0, 0, 0, 0));
    vq.push_back(mk("flush",      0, 32'h0,   1, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 1));
    vq.push_back(mk("fl_wait1",   0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 1));
    vq.push_back(mk("fl_wait2",   0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 1));
    vq.push_back(mk("drop_rsp",   0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'h55,       0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 1));
    vq.push_back(mk("idle3",      0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 0));
    vq.push_back(mk("if_req3",    1, 32'h700, 0, 0, 0, 32'h0,   4'h0, 32'h0,    1, 0, 32'h0,        1, 0, 32'h700, 4'hf, 32'h0,    1, 0, 0, 0, 0));
    vq.push_back(mk("fl_rsp",     0, 32'h0,   1, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'h66,       0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 1));
    vq.push_back(mk("if_req4",    1, 32'h800, 0, 0, 0, 32'h0,   4'h0, 32'h0,    1, 0, 32'h0,        1, 0, 32'h800, 4'hf, 32'h0,    1, 0, 0, 0, 0));
    vq.push_back(mk("if_rsp4",    0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'h77,       0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 1, 0, 1));
    vq.push_back(mk("fl_blk",     1, 32'h900, 1, 0, 0, 32'h0,   4'h0, 32'h0,    1, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 0));
    vq.push_back(mk("stray",      0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 1, 32'h99,       0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 0));
    vq.push_back(mk("idle4",      0, 32'h0,   0, 0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 32'h0,        0, 0, 32'h0,   4'h0, 32'h0,    0, 0, 0, 0, 0));

    // Reset state
    @(negedge clk);
    #1;
    chk("rst.bus_req",   32'(bus_req_o),   32'h0);
    chk("rst.ls_gnt",    32'(ls_gnt_o),    32'h0);
    chk("rst.if_gnt",    32'(if_gnt_o),    32'h0);
    chk("rst.ls_rvalid", 32'(ls_rvalid_o), 32'h0);
    chk("rst.if_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("rst.busy",      32'(arb_busy_o),  32'h0);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven cycles: inputs applied after negedge, outputs checked
    // before the next posedge; state carries from one row to the next.
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].ifr, vq[i].ifa, vq[i].fl, vq[i].lsr, vq[i].we, vq[i].lsa,
            vq[i].st, vq[i].wd, vq[i].g, vq[i].rv, vq[i].rd);
      #1;
      chk({vq[i].name, ".bus_req"},   32'(bus_req_o),   32'(vq[i].e_req));
      chk({vq[i].name, ".bus_we"},    32'(bus_we_o),    32'(vq[i].e_we));
      chk({vq[i].name, ".bus_addr"},  bus_addr_o,       vq[i].e_addr);
      chk({vq[i].name, ".bus_be"},    32'(bus_be_o),    32'(vq[i].e_be));
      chk({vq[i].name, ".bus_wdata"}, bus_wdata_o,      vq[i].e_wd);
      chk({vq[i].name, ".if_gnt"},    32'(if_gnt_o),    32'(vq[i].e_ifg));
      chk({vq[i].name, ".ls_gnt"},    32'(ls_gnt_o),    32'(vq[i].e_lsg));
      chk({vq[i].name, ".if_rvalid"}, 32'(if_rvalid_o), 32'(vq[i].e_ifv));
      chk({vq[i].name, ".ls_rvalid"}, 32'(ls_rvalid_o), 32'(vq[i].e_lsv));
      chk({vq[i].name, ".busy"},      32'(arb_busy_o),  32'(vq[i].e_busy));
      if (vq[i].e_lsv) chk({vq[i].name, ".ls_rdata"}, ls_rdata_o, vq[i].rd);
      if (vq[i].e_ifv) chk({vq[i].name, ".if_rdata"}, if_rdata_o, vq[i].rd);
    end

    // Starvation: both masters request every cycle against a 1-cycle slave.
    // Expected owner per cycle with limit 4: LS LS LS LS IF LS.
    for (int c = 0; c < 6; c++) begin
      logic exp_ls;
      exp_ls = (c != 4);
      @(negedge clk);
      drive(1, 32'hA00, 0, 1, 0, 32'hB00, 4'h0, 32'h0, 1, (c > 0), 32'h0);
      #1;
      chk($sformatf("starve%0d.ls_gnt", c), 32'(ls_gnt_o), 32'(exp_ls));
      chk($sformatf("starve%0d.if_gnt", c), 32'(if_gnt_o), 32'(!exp_ls));
      chk($sformatf("starve%0d.addr", c), bus_addr_o, exp_ls ? 32'hB00 : 32'hA00);
      if (c == 5) chk("starve5.if_rvalid", 32'(if_rvalid_o), 32'h1);
    end
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h0);
    #1;
    chk("starve_end.ls_rvalid", 32'(ls_rvalid_o), 32'h1);

    // Reset asserted during LS_PEND with requests and response present.
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 0, 32'hC00, 4'h0, 32'h0, 1, 0, 32'h0);
    #1;
    chk("rstm.grant", 32'(ls_gnt_o), 32'h1);
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 0, 32'hC04, 4'h0, 32'h0, 1, 1, 32'hABCD);
    #1;
    chk("rstm.pre_lsv", 32'(ls_rvalid_o), 32'h1);
    chk("rstm.pre_req", 32'(bus_req_o),   32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstm.bus_req",   32'(bus_req_o),   32'h0);
    chk("rstm.ls_gnt",    32'(ls_gnt_o),    32'h0);
    chk("rstm.ls_rvalid", 32'(ls_rvalid_o), 32'h0);
    chk("rstm.if_rvalid", 32'(if_rvalid_o), 32'h0);
    chk("rstm.if_gnt",    32'(if_gnt_o),    32'h0);
    chk("rstm.busy",      32'(arb_busy_o),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'hABCD);
    #1;
    chk("post.stray_lsv", 32'(ls_rvalid_o), 32'h0);
    chk("post.stray_ifv", 32'(if_rvalid_o), 32'h0);
    chk("post.busy",      32'(arb_busy_o),  32'h0);
    @(negedge clk);
    drive(0, 32'h0, 0, 1, 0, 32'hD00, 4'h0, 32'h0, 1, 0, 32'h0);
    #1;
    chk("post.ls_gnt", 32'(ls_gnt_o),   32'h1);
    chk("post.addr",   bus_addr_o,      32'hD00);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 32'h5A5A);
    #1;
    chk("post.ls_rvalid", 32'(ls_rvalid_o), 32'h1);
    chk("post.ls_rdata",  ls_rdata_o,       32'h5A5A);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
